// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank: reset level, default
// geometry, read/write half-select encodings and CSR-side counter indices.
package perf_counter_bank_pkg;

    localparam logic RST_ENABLE     = 1'b0;
    localparam int   CNT_W_DEF      = 64;
    localparam int   N_CNT_DEF      = 4;
    localparam logic RD_LO          = 1'b0;
    localparam logic RD_HI          = 1'b1;
    localparam int   STABLE_CNT_IDX = 0;

    // Index width for n counters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_cell.sv
// perf_counter_cell: one counter of the bank. Holds the count and its sticky
// overflow flag. A software write to either half takes priority over the
// increment of the same cycle and never produces an overflow.
module perf_counter_cell
    import perf_counter_bank_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze_i,
    input  logic             inc_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wr_data_i,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count and flag: write beats increment, flag set beats clear.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~ovf_clr_i;
        if (wr_lo_i) begin
            cnt_d[31:0] = wr_data_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_W-1:32] = wr_data_i[HI_W-1:0];
        end else if (inc_i && !freeze_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    // Count and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N_CNT counters of CNT_W bits. Channel 0 is the free
// running stable timer, the others count pipeline events. Provides software
// write, global freeze, sticky overflow flags with an interrupt and a
// registered 32-bit read port with hi/lo select.
// Optional macro PERF_CNT_SNAPSHOT_EN: a lo read latches the upper half into
// a single shadow register, which a later hi read returns.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CNT = N_CNT_DEF,
    parameter int IDX_W = idx_width(N_CNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze_i,
    input  logic [N_CNT-1:0] inc_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wr_data_i,
    input  logic [N_CNT-1:0] ovf_clr_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             rd_hi_i,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    output logic [N_CNT-1:0] ovf_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] cnt0_o
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt [N_CNT];
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_in_range;
    logic [31:0]      rd_hi_sel;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q;

    for (genvar i = 0; i < N_CNT; i++) begin : g_cell
        logic wr_sel;
        // Out-of-range write indices match no cell and are dropped.
        assign wr_sel = wr_en_i && (int'(wr_idx_i) == i);

        perf_counter_cell #(.CNT_W(CNT_W)) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .freeze_i  (freeze_i),
            .inc_i     ((i == STABLE_CNT_IDX) ? 1'b1 : inc_i[i]),
            .wr_lo_i   (wr_sel && (wr_hi_i == RD_LO)),
            .wr_hi_i   (wr_sel && (wr_hi_i == RD_HI)),
            .wr_data_i (wr_data_i),
            .ovf_clr_i (ovf_clr_i[i]),
            .cnt_o     (cnt[i]),
            .ovf_o     (ovf_o[i])
        );
    end

    // Read mux: pre-edge counter value, zero for an out-of-range index.
    always_comb begin
        rd_cnt      = '0;
        rd_in_range = int'(rd_idx_i) < N_CNT;
        for (int i = 0; i < N_CNT; i++) begin
            if (int'(rd_idx_i) == i) rd_cnt = cnt[i];
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [HI_W-1:0] shadow_q, shadow_d;

    // Lo reads capture the upper half so the following hi read is coherent.
    always_comb begin
        shadow_d = shadow_q;
        if (rd_en_i && (rd_hi_i == RD_LO)) shadow_d = rd_cnt[CNT_W-1:32];
        rd_hi_sel            = '0;
        rd_hi_sel[HI_W-1:0]  = shadow_q;
    end

    // Shadow register.
    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) shadow_q <= '0;
        else                     shadow_q <= shadow_d;
    end
`else
    // Hi reads return the live upper half, zero-extended.
    always_comb begin
        rd_hi_sel           = '0;
        rd_hi_sel[HI_W-1:0] = rd_cnt[CNT_W-1:32];
    end
`endif

    // Read data is loaded on a request and held otherwise.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (!rd_in_range)             rd_data_d = '0;
            else if (rd_hi_i == RD_HI)    rd_data_d = rd_hi_sel;
            else                          rd_data_d = rd_cnt[31:0];
        end
    end

    // Read port registers; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_o      = |ovf_o;
    assign cnt0_o     = cnt[STABLE_CNT_IDX];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the bank.
module tb_perf_counter_bank;

    localparam int CNT_W = 64;
    localparam int N_CNT = 5;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             freeze_i;
    logic [N_CNT-1:0] inc_i;
    logic             wr_en_i;
    logic [IDX_W-1:0] wr_idx_i;
    logic             wr_hi_i;
    logic [31:0]      wr_data_i;
    logic [N_CNT-1:0] ovf_clr_i;
    logic             rd_en_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_hi_i;
    logic [31:0]      rd_data_o;
    logic             rd_valid_o;
    logic [N_CNT-1:0] ovf_o;
    logic             irq_o;
    logic [CNT_W-1:0] cnt0_o;

    always #5 clk = ~clk;

    perf_counter_bank #(.CNT_W(CNT_W), .N_CNT(N_CNT), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze_i   (freeze_i),
        .inc_i      (inc_i),
        .wr_en_i    (wr_en_i),
        .wr_idx_i   (wr_idx_i),
        .wr_hi_i    (wr_hi_i),
        .wr_data_i  (wr_data_i),
        .ovf_clr_i  (ovf_clr_i),
        .rd_en_i    (rd_en_i),
        .rd_idx_i   (rd_idx_i),
        .rd_hi_i    (rd_hi_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .ovf_o      (ovf_o),
        .irq_o      (irq_o),
        .cnt0_o     (cnt0_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    logic [63:0]      m_cnt [N_CNT];
    logic [N_CNT-1:0] m_ovf;
    logic [31:0]      m_rd_data;
    logic             m_rd_valid;
    logic [31:0]      m_shadow;
    bit               snap;
    logic [63:0]      saved0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply the bank's rules to the model for the coming clock edge.
    task automatic model_edge();
        logic [63:0] c;
        int ri;
        if (!rst_n) begin
            for (int i = 0; i < N_CNT; i++) m_cnt[i] = 64'd0;
            m_ovf      = '0;
            m_rd_data  = 32'd0;
            m_rd_valid = 1'b0;
            m_shadow   = 32'd0;
        end else begin
            ri         = int'(rd_idx_i);
            m_rd_valid = rd_en_i;
            if (rd_en_i) begin
                c = (ri < N_CNT) ? m_cnt[ri] : 64'd0;
                if (rd_hi_i) begin
                    if (ri >= N_CNT) m_rd_data = 32'd0;
                    else             m_rd_data = snap ? m_shadow : c[63:32];
                end else begin
                    m_rd_data = c[31:0];
                    m_shadow  = c[63:32];
                end
            end
            for (int i = 0; i < N_CNT; i++) begin
                if (ovf_clr_i[i]) m_ovf[i] = 1'b0;
                if (wr_en_i && int'(wr_idx_i) == i) begin
                    if (wr_hi_i) m_cnt[i][63:32] = wr_data_i;
                    else         m_cnt[i][31:0]  = wr_data_i;
                end else if (!freeze_i && (i == 0 || inc_i[i])) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] + 64'd1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_valid", 64'(rd_valid_o), 64'(m_rd_valid));
        chk("rd_data",  64'(rd_data_o),  64'(m_rd_data));
        chk("ovf",      64'(ovf_o),      64'(m_ovf));
        chk("irq",      64'(irq_o),      64'(|m_ovf));
        chk("cnt0",     cnt0_o,          m_cnt[0]);
    endtask

    task automatic idle();
        freeze_i  = 1'b0;
        inc_i     = '0;
        wr_en_i   = 1'b0;
        wr_idx_i  = '0;
        wr_hi_i   = 1'b0;
        wr_data_i = 32'd0;
        ovf_clr_i = '0;
        rd_en_i   = 1'b0;
        rd_idx_i  = '0;
        rd_hi_i   = 1'b0;
    endtask

    task automatic wr(input int idx, input logic hi, input logic [31:0] data);
        wr_en_i   = 1'b1;
        wr_idx_i  = IDX_W'(idx);
        wr_hi_i   = hi;
        wr_data_i = data;
    endtask

    task automatic rd(input int idx, input logic hi);
        rd_en_i  = 1'b1;
        rd_idx_i = IDX_W'(idx);
        rd_hi_i  = hi;
    endtask

    initial begin
`ifdef PERF_CNT_SNAPSHOT_EN
        snap = 1'b1;
`else
        snap = 1'b0;
`endif
        idle();
        rst_n = 1'b0;
        repeat (5) step();
        chk("reset_cnt0",  cnt0_o, 64'd0);
        chk("reset_ovf",   64'(ovf_o), 64'd0);
        chk("reset_valid", 64'(rd_valid_o), 64'd0);
        rst_n = 1'b1;

        // 1: channel 0 counts from release
        repeat (10) step();
        rd(0, 1'b0); step(); idle();
        chk("t1_ch0_lo", 64'(rd_data_o), 64'd10);
        chk("t1_valid",  64'(rd_valid_o), 64'd1);
        step();
        chk("t1_valid_pulse", 64'(rd_valid_o), 64'd0);

        // 2: wrap sets sticky flag and irq, clear drops them
        wr(1, 1'b0, 32'hFFFF_FFFF); step();
        wr(1, 1'b1, 32'hFFFF_FFFF); step(); idle();
        inc_i[1] = 1'b1; step(); idle();
        chk("t2_ovf1", 64'(ovf_o[1]), 64'd1);
        chk("t2_irq",  64'(irq_o), 64'd1);
        rd(1, 1'b0); step(); idle();
        chk("t2_wrap_lo", 64'(rd_data_o), 64'd0);
        ovf_clr_i[1] = 1'b1; step(); idle();
        chk("t2_clr_ovf1", 64'(ovf_o[1]), 64'd0);
        chk("t2_clr_irq",  64'(irq_o), 64'd0);

        // 3: set wins over clear
        wr(1, 1'b0, 32'hFFFF_FFFF); step();
        wr(1, 1'b1, 32'hFFFF_FFFF); step(); idle();
        inc_i[1] = 1'b1; ovf_clr_i[1] = 1'b1; step(); idle();
        chk("t3_set_wins", 64'(ovf_o[1]), 64'd1);
        ovf_clr_i[1] = 1'b1; step(); idle();

        // 4: write beats increment, freeze holds counters
        wr(2, 1'b0, 32'd5); inc_i[2] = 1'b1; step(); idle();
        rd(2, 1'b0); step(); idle();
        chk("t4_wr_beats_inc", 64'(rd_data_o), 64'd5);
        saved0 = m_cnt[0];
        repeat (20) begin
            freeze_i = 1'b1;
            inc_i    = N_CNT'($urandom);
            step();
        end
        inc_i = '0;
        rd(2, 1'b0); step(); idle();
        chk("t4_frz_cnt0", cnt0_o, saved0);
        chk("t4_frz_ch2",  64'(rd_data_o), 64'd5);

        // 5: lo then hi across a carry
        wr(3, 1'b0, 32'hFFFF_FFFF); step();
        wr(3, 1'b1, 32'd1); step(); idle();
        rd(3, 1'b0); step(); idle();
        chk("t5_lo", 64'(rd_data_o), 64'hFFFF_FFFF);
        inc_i[3] = 1'b1; step(); idle();
        rd(3, 1'b1); step(); idle();
        chk("t5_hi", 64'(rd_data_o), snap ? 64'd1 : 64'd2);

        // 6: out-of-range read, then reset drops a pending read
        rd(N_CNT, 1'b0); step(); idle();
        chk("t6_oor_data",  64'(rd_data_o), 64'd0);
        chk("t6_oor_valid", 64'(rd_valid_o), 64'd1);
        rd(3, 1'b0); step(); idle();
        rst_n = 1'b0; step();
        chk("t6_rst_valid", 64'(rd_valid_o), 64'd0);
        chk("t6_rst_cnt0",  cnt0_o, 64'd0);
        rst_n = 1'b1;

        // Random traffic
        repeat (2500) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            freeze_i  = ($urandom_range(0, 7) == 0);
            inc_i     = N_CNT'($urandom);
            wr_en_i   = ($urandom_range(0, 5) == 0);
            wr_idx_i  = IDX_W'($urandom_range(0, 7));
            wr_hi_i   = 1'($urandom_range(0, 1));
            wr_data_i = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom);
            ovf_clr_i = ($urandom_range(0, 7) == 0) ? N_CNT'($urandom) : '0;
            rd_en_i   = 1'($urandom_range(0, 1));
            rd_idx_i  = IDX_W'($urandom_range(0, 7));
            rd_hi_i   = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
